// File: rtl/count_nest_yi.sv
// count_nest_yi: cascaded nested-loop counter.
// Level 0 is the innermost loop. Each level counts 0..final and then wraps.
// A level advances only when every inner level is at its final value.
// With ONESHOT=1 the counter stops after one full sweep and raises done.
module count_nest_yi #(
  parameter int BITS_OF_END_NUMBER = 10,
  parameter int LEVELS             = 3,
  parameter int ONESHOT            = 0
) (
  input  logic                                 clk,
  input  logic                                 reset,
  input  logic                                 enable,
  input  logic                                 clear,
  input  logic [LEVELS*BITS_OF_END_NUMBER-1:0] final_number,
  output logic [LEVELS*BITS_OF_END_NUMBER-1:0] total_q,
  output logic [LEVELS-1:0]                    last,
  output logic                                 done
);

  localparam int B = BITS_OF_END_NUMBER;

  logic [LEVELS-1:0][B-1:0] cnt_q;
  logic [LEVELS-1:0][B-1:0] cnt_d;
  logic [LEVELS-1:0][B-1:0] fin;
  logic [LEVELS-1:0]        at_final;
  logic [LEVELS-1:0]        carry;
  logic                     step;
  logic                     done_q;

  assign fin     = final_number;
  assign total_q = cnt_q;
  assign done    = done_q;

  // Carry chain, wrap flags and next counts; reset gates step so last stays low.
  always_comb begin
    at_final = '0;
    carry    = '0;
    last     = '0;
    cnt_d    = cnt_q;
    step     = enable & ~done_q & ~clear & ~reset;
    for (int k = 0; k < LEVELS; k++) begin
      at_final[k] = (cnt_q[k] >= fin[k]);
    end
    carry[0] = 1'b1;
    for (int k = 1; k < LEVELS; k++) begin
      carry[k] = carry[k-1] & at_final[k-1];
    end
    for (int k = 0; k < LEVELS; k++) begin
      last[k] = step & carry[k] & at_final[k];
      if (step && carry[k]) begin
        // A count only increments while below final, so it cannot overflow.
        cnt_d[k] = at_final[k] ? '0 : B'(cnt_q[k] + 1'b1);
      end
    end
  end

  // Count and done registers; clear outranks enable, reset outranks everything.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt_q  <= '0;
      done_q <= 1'b0;
    end else if (clear) begin
      cnt_q  <= '0;
      done_q <= 1'b0;
    end else begin
      cnt_q <= cnt_d;
      // Outermost wrap is the full-sweep event; every level lands on 0 with it.
      if (ONESHOT != 0 && last[LEVELS-1]) begin
        done_q <= 1'b1;
      end
    end
  end

endmodule
